axil_arbiter_wr: RTL and testbench
==================================

Name: axil_arbiter_wr

Overview:
- Write-path arbiter for the AXI-Lite interconnect; sits directly upstream of the write crossbar.
- Decodes each master's AW address to a target slave.
- Runs an independent round-robin arbiter per slave and drives the registered one-hot grant_wr matrix that steers the crossbar.
- Holds each grant from first selection until the write response (B) handshake completes on that slave.

Parameters:
- NUMBER_MASTER, 2, number of AXI-Lite masters (≥2).
- NUMBER_SLAVE, 4, number of AXI-Lite slaves (power of two, ≥2).
- AXI_ADDR_WIDTH, 8, AW address width (> $clog2(NUMBER_SLAVE)).

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous, active-high reset.
- m_axil_awaddr  in  AXI_ADDR_WIDTH x [NUMBER_MASTER]  per-master write address (unpacked array).
- m_axil_awvalid  in  NUMBER_MASTER  per-master AW valid.
- s_axil_bvalid  in  NUMBER_SLAVE  per-slave B valid.
- s_axil_bready  in  NUMBER_SLAVE  per-slave B ready (crossbar output, sourced from the granted master).
- grant_wr  out  NUMBER_MASTER x [NUMBER_SLAVE]  per-slave one-hot grant; bit k of grant_wr[i] means master k owns slave i.

Behaviour:
- Clocking/reset: single clock domain; reset is synchronous and active-high (aclk, areset).
- Reset values: all grant_wr[i] = 0, all per-slave round-robin pointers = 0, all slave FSMs in IDLE.
- Address decode: target slave = m_axil_awaddr[k][AXI_ADDR_WIDTH-1 -: $clog2(NUMBER_SLAVE)], i.e. equal-sized regions. The map has no holes, so no decode error path exists.
- master_busy[k] = OR over i of grant_wr[i][k].
- req[i][k] = m_axil_awvalid[k] & (decode(k) == i) & ~master_busy[k].
- Per-slave FSM, two states:
  - IDLE: if |req[i], select the first requesting master scanning from ptr[i] upward with wrap-around. At the next edge: grant_wr[i] = onehot(sel), ptr[i] = (sel+1) mod NUMBER_MASTER, state = BUSY. If no request, stay IDLE with grant 0.
  - BUSY: grant_wr[i] held constant and ignores all AW activity, including awvalid dropping after the AW handshake and new requests from other masters. On s_axil_bvalid[i] & s_axil_bready[i]: at the next edge grant_wr[i] = 0, state = IDLE.
- Latency:
  - Request to grant: 1 cycle (grant visible the cycle after awvalid is first sampled).
  - Minimum gap between successive grants on the same slave: 1 IDLE cycle after the grant clears.
- Grant invariants:
  - grant_wr[i] is always zero or one-hot.
  - A master is never granted on two slaves at once.
  - A master requests a different slave while still busy: the request is masked until its grant clears.
- Concurrency: different slaves arbitrate independently and may grant different masters in the same cycle.
- Pointer rule: ptr[i] advances only when a grant is issued.
- Handshake rules:
  - B handshake while IDLE: ignored.
  - bvalid without bready: grant held.
  - awvalid deasserted before grant: no grant, pointer unchanged.
- Reset mid-transaction: the next edge clears all grants, pointers and states regardless of outstanding handshakes.

Test Plan (NUMBER_MASTER=2, NUMBER_SLAVE=4, AXI_ADDR_WIDTH=8; slave = awaddr[7:6]):
- Reset with m_axil_awvalid=2'b11 held → grant_wr all 0 while areset=1; first grant appears 1 cycle after areset falls.
- M0 awaddr=8'h45, awvalid=1 → grant_wr[1]=2'b01 next cycle; held through awvalid drop; clears 1 cycle after s_axil_bvalid[1]&s_axil_bready[1].
- M0 awaddr=8'h10, M1 awaddr=8'h20, both valid in the same cycle, ptr[0]=0 → grant_wr[0]=2'b01. After its B handshake and the idle cycle, M1 (still valid) → grant_wr[0]=2'b10. Next simultaneous request → 2'b01 (round-robin alternation).
- M0 to 8'hC0 and M1 to 8'h80 simultaneously → grant_wr[3]=2'b01 and grant_wr[2]=2'b10 in the same cycle.
- M0 granted on slave 1 (B pending); M0 raises awvalid with awaddr=8'h00 → grant_wr[0] stays 0 until the slave-1 grant clears, then grant_wr[0]=2'b01.
- bvalid=1 with bready=0 for 5 cycles → grant held; bready=1 → grant clears next edge. Assert areset while BUSY → all grants 0 next edge; ptr back to 0.

Source files
------------

// File: rtl/axil_arbiter_wr.sv
// axil_arbiter_wr: per-slave round-robin AW arbiter driving a registered one-hot write grant matrix
module axil_arbiter_wr #(
  parameter int NUMBER_MASTER  = 2,
  parameter int NUMBER_SLAVE   = 4,
  parameter int AXI_ADDR_WIDTH = 8
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [AXI_ADDR_WIDTH-1:0] m_axil_awaddr [NUMBER_MASTER],
  input  logic [NUMBER_MASTER-1:0]  m_axil_awvalid,
  input  logic [NUMBER_SLAVE-1:0]   s_axil_bvalid,
  input  logic [NUMBER_SLAVE-1:0]   s_axil_bready,
  output logic [NUMBER_MASTER-1:0]  grant_wr [NUMBER_SLAVE]
);
  localparam int SW = $clog2(NUMBER_SLAVE);
  localparam int PW = (NUMBER_MASTER > 1) ? $clog2(NUMBER_MASTER) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t                   state   [NUMBER_SLAVE];
  state_t                   state_n [NUMBER_SLAVE];
  logic [PW-1:0]            ptr     [NUMBER_SLAVE];
  logic [PW-1:0]            ptr_n   [NUMBER_SLAVE];
  logic [NUMBER_MASTER-1:0] grant_n [NUMBER_SLAVE];
  logic [NUMBER_MASTER-1:0] req     [NUMBER_SLAVE];
  logic [NUMBER_MASTER-1:0] master_busy;
  logic                     unused_addr;
  // only the top address bits select a slave; fold the rest away
  always_comb begin
    unused_addr = 1'b0;
    for (int k = 0; k < NUMBER_MASTER; k++) unused_addr ^= ^m_axil_awaddr[k];
  end
  // a master holding any grant may not request another slave
  always_comb begin
    master_busy = '0;
    for (int i = 0; i < NUMBER_SLAVE; i++) master_busy |= grant_wr[i];
  end
  // per-slave request vector from address decode, masked by busy masters
  always_comb begin
    for (int i = 0; i < NUMBER_SLAVE; i++)
      for (int k = 0; k < NUMBER_MASTER; k++)
        req[i][k] = m_axil_awvalid[k] && (m_axil_awaddr[k][AXI_ADDR_WIDTH-1 -: SW] == SW'(i)) && !master_busy[k];
  end
  // round-robin pick in IDLE, hold grant in BUSY until the B handshake
  always_comb begin
    logic [PW-1:0] sel;
    logic [PW-1:0] idx;
    sel = '0;
    idx = '0;
    for (int i = 0; i < NUMBER_SLAVE; i++) begin
      state_n[i] = state[i];
      grant_n[i] = grant_wr[i];
      ptr_n[i]   = ptr[i];
      sel        = '0;
      for (int j = NUMBER_MASTER - 1; j >= 0; j--) begin
        idx = PW'((int'(ptr[i]) + j) % NUMBER_MASTER);
        sel = req[i][idx] ? idx : sel;
      end
      if (state[i] == IDLE && |req[i]) begin
        state_n[i] = BUSY;
        grant_n[i] = NUMBER_MASTER'(1) << sel;
        ptr_n[i]   = PW'((int'(sel) + 1) % NUMBER_MASTER);
      end else if (state[i] == BUSY && s_axil_bvalid[i] && s_axil_bready[i]) begin
        state_n[i] = IDLE;
        grant_n[i] = '0;
      end
    end
  end
  // state, pointer and grant registers
  always_ff @(posedge aclk) begin
    for (int i = 0; i < NUMBER_SLAVE; i++) begin
      state[i]    <= areset ? IDLE : state_n[i];
      ptr[i]      <= areset ? '0 : ptr_n[i];
      grant_wr[i] <= areset ? '0 : grant_n[i];
    end
  end
endmodule

// File: tb/tb_axil_arbiter_wr.sv
// tb_axil_arbiter_wr: scoreboard-driven bench for the write arbiter grant matrix
module tb_axil_arbiter_wr;
  logic       aclk = 1'b0;
  logic       areset;
  logic [7:0] m_axil_awaddr [2];
  logic [1:0] m_axil_awvalid;
  logic [3:0] s_axil_bvalid;
  logic [3:0] s_axil_bready;
  logic [1:0] grant_wr [4];
  logic [7:0] flat;
  typedef struct {
    string      name;
    logic [7:0] exp;
  } item_t;
  item_t q[$];
  item_t it;
  int checks = 0;
  int errors = 0;

  axil_arbiter_wr #(.NUMBER_MASTER(2), .NUMBER_SLAVE(4), .AXI_ADDR_WIDTH(8)) dut (
    .aclk(aclk),
    .areset(areset),
    .m_axil_awaddr(m_axil_awaddr),
    .m_axil_awvalid(m_axil_awvalid),
    .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready),
    .grant_wr(grant_wr)
  );

  always #5 aclk = ~aclk;
  // flat layout: [1:0]=slave0 [3:2]=slave1 [5:4]=slave2 [7:6]=slave3
  assign flat = {grant_wr[3], grant_wr[2], grant_wr[1], grant_wr[0]};

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    m_axil_awvalid = 2'b00;
    m_axil_awaddr[0] = 8'h00;
    m_axil_awaddr[1] = 8'h00;
    s_axil_bvalid = 4'h0;
    s_axil_bready = 4'h0;
    tick();
    areset = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    m_axil_awaddr[0] = 8'h00;
    m_axil_awaddr[1] = 8'h40;
    m_axil_awvalid = 2'b11;
    s_axil_bvalid = 4'h0;
    s_axil_bready = 4'h0;
    q.push_back('{"reset_hold0", 8'h00});
    tick();
    it = q.pop_front(); checks++; if (flat !== it.exp) begin errors++; $display("FAIL %s: grant=%h expected=%h", it.name, flat, it.exp); end
    q.push_back('{"reset_hold1", 8'h00});
    tick();
    it = q.pop_front(); checks++; if (flat !== it.exp) begin errors++; $display("FAIL %s: grant=%h expected=%h", it.name, flat, it.exp); end
    areset = 1'b0;
    q.push_back('{"reset_first_grant", 8'h09});
    tick();
    it = q.pop_front(); checks++; if (flat !== it.exp) begin errors++; $display("FAIL %s: grant=%h expected=%h", it.name, flat, it.exp); end
    m_axil_awvalid = 2'b00;
    s_axil_bvalid = 4'b0011;
    s_axil_bready = 4'b0011;
    q.push_back('{"reset_cleanup", 8'h00});
    tick();
    it = q.pop_front(); checks++; if (flat !== it.exp) begin errors++; $display("FAIL %s: grant=%h expected=%h", it.name, flat, it.exp); end
  endtask

  task automatic test_single();
    do_reset();
    s_axil_bvalid = 4'b0010;
    s_axil_bready = 4'b0010;
    q.push_back('{"b_while_idle", 8'h00});
    tick();
    it = q.pop_front(); checks++; if (flat !== it.exp) begin errors++; $display("FAIL %s: grant=%h expected=%h", it.name, flat, it.exp); end
    s_axil_bvalid = 4'h0;
    s_axil_bready = 4'h0;
    m_axil_awaddr[0] = 8'h45;
    m_axil_awvalid = 2'b01;
    q.push_back('{"single_grant", 8'h04});
    tick();
    it = q.pop_front(); checks++; if (flat !== it.exp) begin errors++; $display("FAIL %s: grant=%h expected=%h", it.name, flat, it.exp); end
    m_axil_awvalid = 2'b00;
    for (int c = 0; c < 2; c++) begin
      q.push_back('{"single_hold", 8'h04});
      tick();
      it = q.pop_front(); checks++; if (flat !== it.exp) begin errors++; $display("FAIL %s: grant=%h expected=%h", it.name, flat, it.exp); end
    end
    s_axil_bvalid = 4'b0010;
    s_axil_bready = 4'b0010;
    q.push_back('{"single_clear", 8'h00});
    tick();
    it = q.pop_front(); checks++; if (flat !== it.exp) begin errors++; $display("FAIL %s: grant=%h expected=%h", it.name, flat, it.exp); end
    s_axil_bvalid = 4'h0;
    s_axil_bready = 4'h0;
  endtask

  task automatic test_round_robin();
    do_reset();
    m_axil_awaddr[0] = 8'h10;
    m_axil_awaddr[1] = 8'h20;
    m_axil_awvalid = 2'b11;
    q.push_back('{"rr_first_m0", 8'h01});
    tick();
    it = q.pop_front(); checks++; if (flat !== it.exp) begin errors++; $display("FAIL %s: grant=%h expected=%h", it.name, flat, it.exp); end
    m_axil_awvalid = 2'b10;
    s_axil_bvalid = 4'b0001;
    s_axil_bready = 4'b0001;
    q.push_back('{"rr_clear_gap", 8'h00});
    tick();
    it = q.pop_front(); checks++; if (flat !== it.exp) begin errors++; $display("FAIL %s: grant=%h expected=%h", it.name, flat, it.exp); end
    s_axil_bvalid = 4'h0;
    s_axil_bready = 4'h0;
    q.push_back('{"rr_then_m1", 8'h02});
    tick();
    it = q.pop_front(); checks++; if (flat !== it.exp) begin errors++; $display("FAIL %s: grant=%h expected=%h", it.name, flat, it.exp); end
    m_axil_awvalid = 2'b00;
    s_axil_bvalid = 4'b0001;
    s_axil_bready = 4'b0001;
    q.push_back('{"rr_clear2", 8'h00});
    tick();
    it = q.pop_front(); checks++; if (flat !== it.exp) begin errors++; $display("FAIL %s: grant=%h expected=%h", it.name, flat, it.exp); end
    s_axil_bvalid = 4'h0;
    s_axil_bready = 4'h0;
    m_axil_awvalid = 2'b11;
    q.push_back('{"rr_back_to_m0", 8'h01});
    tick();
    it = q.pop_front(); checks++; if (flat !== it.exp) begin errors++; $display("FAIL %s: grant=%h expected=%h", it.name, flat, it.exp); end
    m_axil_awvalid = 2'b00;
  endtask

  task automatic test_concurrent();
    do_reset();
    m_axil_awaddr[0] = 8'hC0;
    m_axil_awaddr[1] = 8'h80;
    m_axil_awvalid = 2'b11;
    q.push_back('{"concurrent_grants", 8'h60});
    tick();
    it = q.pop_front(); checks++; if (flat !== it.exp) begin errors++; $display("FAIL %s: grant=%h expected=%h", it.name, flat, it.exp); end
    m_axil_awvalid = 2'b00;
    s_axil_bvalid = 4'b1000;
    s_axil_bready = 4'b1000;
    q.push_back('{"concurrent_clear_s3", 8'h20});
    tick();
    it = q.pop_front(); checks++; if (flat !== it.exp) begin errors++; $display("FAIL %s: grant=%h expected=%h", it.name, flat, it.exp); end
    s_axil_bvalid = 4'b0100;
    s_axil_bready = 4'b0100;
    q.push_back('{"concurrent_clear_s2", 8'h00});
    tick();
    it = q.pop_front(); checks++; if (flat !== it.exp) begin errors++; $display("FAIL %s: grant=%h expected=%h", it.name, flat, it.exp); end
    s_axil_bvalid = 4'h0;
    s_axil_bready = 4'h0;
  endtask

  task automatic test_busy_mask();
    do_reset();
    m_axil_awaddr[0] = 8'h45;
    m_axil_awvalid = 2'b01;
    q.push_back('{"mask_first", 8'h04});
    tick();
    it = q.pop_front(); checks++; if (flat !== it.exp) begin errors++; $display("FAIL %s: grant=%h expected=%h", it.name, flat, it.exp); end
    m_axil_awaddr[0] = 8'h00;
    for (int c = 0; c < 2; c++) begin
      q.push_back('{"mask_blocked", 8'h04});
      tick();
      it = q.pop_front(); checks++; if (flat !== it.exp) begin errors++; $display("FAIL %s: grant=%h expected=%h", it.name, flat, it.exp); end
    end
    s_axil_bvalid = 4'b0010;
    s_axil_bready = 4'b0010;
    q.push_back('{"mask_release", 8'h00});
    tick();
    it = q.pop_front(); checks++; if (flat !== it.exp) begin errors++; $display("FAIL %s: grant=%h expected=%h", it.name, flat, it.exp); end
    s_axil_bvalid = 4'h0;
    s_axil_bready = 4'h0;
    q.push_back('{"mask_then_s0", 8'h01});
    tick();
    it = q.pop_front(); checks++; if (flat !== it.exp) begin errors++; $display("FAIL %s: grant=%h expected=%h", it.name, flat, it.exp); end
    m_axil_awvalid = 2'b00;
  endtask

  task automatic test_bready_and_reset();
    do_reset();
    m_axil_awaddr[1] = 8'h80;
    m_axil_awvalid = 2'b10;
    q.push_back('{"hold_grant", 8'h20});
    tick();
    it = q.pop_front(); checks++; if (flat !== it.exp) begin errors++; $display("FAIL %s: grant=%h expected=%h", it.name, flat, it.exp); end
    m_axil_awvalid = 2'b00;
    s_axil_bvalid = 4'b0100;
    s_axil_bready = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      q.push_back('{"hold_no_bready", 8'h20});
      tick();
      it = q.pop_front(); checks++; if (flat !== it.exp) begin errors++; $display("FAIL %s: grant=%h expected=%h", it.name, flat, it.exp); end
    end
    s_axil_bready = 4'b0100;
    q.push_back('{"hold_bready_clear", 8'h00});
    tick();
    it = q.pop_front(); checks++; if (flat !== it.exp) begin errors++; $display("FAIL %s: grant=%h expected=%h", it.name, flat, it.exp); end
    s_axil_bvalid = 4'h0;
    s_axil_bready = 4'h0;
    tick();
    m_axil_awaddr[0] = 8'h80;
    m_axil_awvalid = 2'b01;
    q.push_back('{"midrst_grant", 8'h10});
    tick();
    it = q.pop_front(); checks++; if (flat !== it.exp) begin errors++; $display("FAIL %s: grant=%h expected=%h", it.name, flat, it.exp); end
    areset = 1'b1;
    q.push_back('{"midrst_clear", 8'h00});
    tick();
    it = q.pop_front(); checks++; if (flat !== it.exp) begin errors++; $display("FAIL %s: grant=%h expected=%h", it.name, flat, it.exp); end
    areset = 1'b0;
    m_axil_awvalid = 2'b11;
    q.push_back('{"midrst_ptr_zero", 8'h10});
    tick();
    it = q.pop_front(); checks++; if (flat !== it.exp) begin errors++; $display("FAIL %s: grant=%h expected=%h", it.name, flat, it.exp); end
    m_axil_awvalid = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_concurrent();
    test_busy_mask();
    test_bready_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
